snes_pad_poller: RTL and testbench

SNES_PAD_POLLER -- requirements
Module: snes_pad_poller

---
 rtl/snes_pad_poller.sv | 189 ++++++++++++++++++
 tb/tb_snes_pad_poller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snes_pad_poller.sv
// SNES controller poller: periodically (or on request) latches the pad,
// clocks out 16 serial bits, validates the ID nibble and publishes a
// debounced button byte with press/update pulses.
module snes_pad_poller #(
  parameter int unsigned POLL_CYCLES = 833334,
  parameter int unsigned HALF_CYCLES = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       poll_now,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] controller_report,
  output logic [7:0] press_pulse,
  output logic       report_update,
  output logic       pad_present,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CLK_LO,
    S_CLK_HI,
    S_DONE
  } state_t;

  localparam logic [23:0] POLL_LAST  = 24'(POLL_CYCLES - 1);
  localparam logic [16:0] LATCH_LAST = 17'(2 * HALF_CYCLES - 1);
  localparam logic [16:0] HALF_LAST  = 17'(HALF_CYCLES - 1);

  state_t      r_state;
  logic [23:0] r_poll_cnt;
  logic [16:0] r_phase;
  logic [3:0]  r_bit_idx;
  logic [15:0] r_shift;
  logic [7:0]  r_cand;
  logic [7:0]  r_report;
  logic [7:0]  r_press;
  logic        r_update;
  logic        r_present;
  logic        r_latch;
  logic        r_pclk;
  logic        r_busy;
  logic        r_sync_meta;
  logic        r_sync;

  logic        w_wrap;
  logic        w_start;
  logic        w_frame_ok;
  logic [7:0]  w_decoded;

  // Two-flop synchronizer for the asynchronous pad data line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_meta <= 1'b1;
      r_sync      <= 1'b1;
    end else begin
      r_sync_meta <= pad_data;
      r_sync      <= r_sync_meta;
    end
  end

  // Frame triggers, ID check and raw-to-report bit mapping (raw 0 = pressed)
  always_comb begin
    w_wrap     = (r_poll_cnt == POLL_LAST);
    w_start    = (r_state == S_IDLE) && (poll_now || w_wrap);
    w_frame_ok = &r_shift[15:12];
    w_decoded  = {~r_shift[8], ~r_shift[0], ~r_shift[2], ~r_shift[3],
                  ~r_shift[7], ~r_shift[6], ~r_shift[5], ~r_shift[4]};
  end

  // Poll counter, serial FSM and debounced report update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_poll_cnt <= '0;
      r_phase    <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '1;
      r_cand     <= '0;
      r_report   <= '0;
      r_press    <= '0;
      r_update   <= 1'b0;
      r_present  <= 1'b0;
      r_latch    <= 1'b0;
      r_pclk     <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_press  <= '0;
      r_update <= 1'b0;

      // A manual poll in IDLE restarts the period; wraps elsewhere are simply lost
      if ((r_state == S_IDLE && poll_now) || w_wrap) begin
        r_poll_cnt <= '0;
      end else begin
        r_poll_cnt <= r_poll_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_LATCH;
            r_phase <= '0;
            r_latch <= 1'b1;
            r_pclk  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        S_LATCH: begin
          if (r_phase == LATCH_LAST) begin
            r_shift[0] <= r_sync;
            r_bit_idx  <= 4'd1;
            r_phase    <= '0;
            r_state    <= S_CLK_LO;
            r_latch    <= 1'b0;
            r_pclk     <= 1'b0;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end

        S_CLK_LO: begin
          if (r_phase == HALF_LAST) begin
            r_phase <= '0;
            r_state <= S_CLK_HI;
            r_pclk  <= 1'b1;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end

        S_CLK_HI: begin
          if (r_phase == HALF_LAST) begin
            r_shift[r_bit_idx] <= r_sync;
            r_phase            <= '0;
            if (r_bit_idx == 4'd15) begin
              r_state <= S_DONE;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_state   <= S_CLK_LO;
              r_pclk    <= 1'b0;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end

        S_DONE: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_bit_idx <= '0;
          if (w_frame_ok) begin
            r_present <= 1'b1;
            if ((w_decoded == r_cand) && (w_decoded != r_report)) begin
              r_report <= w_decoded;
              r_press  <= w_decoded & ~r_report;
              r_update <= 1'b1;
            end
            r_cand <= w_decoded;
          end else begin
            r_present <= 1'b0;
            r_cand    <= '0;
            r_report  <= '0;
            r_update  <= |r_report;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_latch <= 1'b0;
          r_pclk  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pad_latch         = r_latch;
  assign pad_clk           = r_pclk;
  assign controller_report = r_report;
  assign press_pulse       = r_press;
  assign report_update     = r_update;
  assign pad_present       = r_present;
  assign busy              = r_busy;

endmodule

// File: tb/tb_snes_pad_poller.sv
// Directed bench for snes_pad_poller with a shift-register pad model.
module tb_snes_pad_poller;

  localparam int unsigned HALF = 4;
  localparam int unsigned POLL = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       poll_now = 1'b0;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] controller_report;
  logic [7:0] press_pulse;
  logic       report_update;
  logic       pad_present;
  logic       busy;

  snes_pad_poller #(
    .POLL_CYCLES(POLL),
    .HALF_CYCLES(HALF)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .poll_now         (poll_now),
    .pad_data         (pad_data),
    .pad_latch        (pad_latch),
    .pad_clk          (pad_clk),
    .controller_report(controller_report),
    .press_pulse      (press_pulse),
    .report_update    (report_update),
    .pad_present      (pad_present),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // Pad model: parallel load while latched, shift on each pad_clk rise
  logic [15:0] m_raw = 16'hFFFF;
  logic [15:0] m_sh = 16'hFFFF;
  logic        m_pclk_d = 1'b1;
  logic        m_disc = 1'b0;

  assign pad_data = m_disc ? 1'b0 : m_sh[0];

  always @(posedge clk) begin
    if (pad_latch) m_sh <= m_raw;
    else if (pad_clk && !m_pclk_d) m_sh <= {1'b1, m_sh[15:1]};
    m_pclk_d <= pad_clk;
  end

  // Waveform statistics sampled on the falling edge
  int unsigned n_latch = 0, n_busy = 0, n_lo = 0, n_fall = 0, n_badlo = 0, lo_run = 0;
  logic        prev_pclk = 1'b1;

  always @(negedge clk) begin
    if (pad_latch) n_latch <= n_latch + 1;
    if (busy) n_busy <= n_busy + 1;
    if (!pad_clk) begin
      n_lo   <= n_lo + 1;
      lo_run <= lo_run + 1;
      if (prev_pclk) n_fall <= n_fall + 1;
    end else if (!prev_pclk) begin
      if (lo_run != HALF) n_badlo <= n_badlo + 1;
      lo_run <= 0;
    end
    prev_pclk <= pad_clk;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the frame to finish; returns at the first idle sample
  task automatic wait_idle();
    int unsigned k;
    k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_eq("frame_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_frame(input logic [15:0] raw);
    m_raw = raw;
    @(negedge clk);
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    wait_idle();
  endtask

  task automatic check_frame(input string tag, input logic [7:0] rep, input logic [7:0] prs,
                             input logic upd, input logic pres);
    check_eq({tag, "_report"}, {24'd0, controller_report}, {24'd0, rep});
    check_eq({tag, "_press"}, {24'd0, press_pulse}, {24'd0, prs});
    check_eq({tag, "_update"}, {31'd0, report_update}, {31'd0, upd});
    check_eq({tag, "_present"}, {31'd0, pad_present}, {31'd0, pres});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_latch"}, {31'd0, pad_latch}, 32'd0);
    check_eq({tag, "_pclk"}, {31'd0, pad_clk}, 32'd1);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_frame(tag, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  int unsigned t;
  int unsigned s_latch, s_busy, s_lo, s_fall, s_bad;
  logic        saw_upd;

  task automatic step();
    @(negedge clk);
    t++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then first automatic poll exactly POLL cycles after release
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    t = 0;
    while (!busy && t < 1000) step();
    check_eq("first_auto_poll", t, POLL);
    wait_idle();
    check_frame("idle_frame", 8'h00, 8'h00, 1'b0, 1'b1);

    // Start pressed, first frame only primes the debounce candidate; timing measured here
    s_latch = n_latch; s_busy = n_busy; s_lo = n_lo; s_fall = n_fall; s_bad = n_badlo;
    run_frame(16'hFFF7);
    check_frame("start_f1", 8'h00, 8'h00, 1'b0, 1'b1);
    check_eq("latch_cycles", n_latch - s_latch, 2 * HALF);
    check_eq("busy_cycles", n_busy - s_busy, 32 * HALF + 1);
    check_eq("clk_falls", n_fall - s_fall, 15);
    check_eq("clk_low_cycles", n_lo - s_lo, 15 * HALF);
    check_eq("clk_low_width_errs", n_badlo - s_bad, 0);

    run_frame(16'hFFF7);
    check_frame("start_f2", 8'h10, 8'h10, 1'b1, 1'b1);
    @(negedge clk);
    check_eq("press_clears", {24'd0, press_pulse}, 32'd0);
    check_eq("update_clears", {31'd0, report_update}, 32'd0);
    run_frame(16'hFFF7);
    check_frame("start_f3", 8'h10, 8'h00, 1'b0, 1'b1);

    // Disconnected pad: data stuck low gives an invalid ID nibble
    m_disc = 1'b1;
    run_frame(16'hFFFF);
    check_frame("disc_f1", 8'h00, 8'h00, 1'b1, 1'b0);
    run_frame(16'hFFFF);
    check_frame("disc_f2", 8'h00, 8'h00, 1'b0, 1'b0);
    m_disc = 1'b0;

    // Alternating A / nothing never settles
    for (int i = 0; i < 4; i++) begin
      run_frame((i % 2 == 0) ? 16'hFEFF : 16'hFFFF);
      check_frame("alternate", 8'h00, 8'h00, 1'b0, 1'b1);
    end
    run_frame(16'hFEFF);
    run_frame(16'hFEFF);
    check_frame("a_pressed", 8'h80, 8'h80, 1'b1, 1'b1);

    // B + Up + Right
    run_frame(16'hFF6E);
    check_frame("bur_f1", 8'h80, 8'h00, 1'b0, 1'b1);
    run_frame(16'hFF6E);
    check_frame("bur_f2", 8'h49, 8'h49, 1'b1, 1'b1);

    // Down + Left + Select + A, with Y and X pressed too (not reported)
    run_frame(16'hFC99);
    run_frame(16'hFC99);
    check_frame("dlsa", 8'hA6, 8'hA6, 1'b1, 1'b1);

    // Only id3 low: invalid frame
    run_frame(16'h7FFF);
    check_frame("bad_id", 8'h00, 8'h00, 1'b1, 1'b0);

    // Reset during the low phase of bit 7
    run_frame(16'hFFF7);
    run_frame(16'hFFF7);
    check_frame("pre_reset", 8'h10, 8'h10, 1'b1, 1'b1);
    @(negedge clk);
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    s_fall = n_fall;
    t = 0;
    while ((n_fall - s_fall) < 7 && t < 300) step();
    check_eq("reached_bit7_low", {31'd0, pad_clk}, 32'd0);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    check_reset_outputs("midreset_hold");
    reset = 1'b0;
    t = 0;
    saw_upd = 1'b0;
    while (!busy && t < 1000) begin
      step();
      saw_upd |= report_update;
    end
    check_eq("post_reset_poll", t, POLL);
    check_eq("post_reset_no_update", {31'd0, saw_upd}, 32'd0);
    wait_idle();
    check_frame("post_reset_frame", 8'h00, 8'h00, 1'b0, 1'b1);

    // poll_now inside a frame is ignored and does not restart the period
    @(negedge clk);
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    t = 0;
    while (t < 40) step();
    poll_now = 1'b1;
    step();
    poll_now = 1'b0;
    while (busy && t < 300) step();
    check_eq("ignored_poll_frame_end", t, 32 * HALF + 1);
    while (!busy && t < 500) step();
    check_eq("next_wrap_start", t, POLL);
    while (busy && t < 700) step();
    check_eq("wrap_frame_end", t, POLL + 32 * HALF + 1);

    // poll_now on the same edge as a wrap starts one frame
    while (t < 2 * POLL - 1) step();
    poll_now = 1'b1;
    step();
    poll_now = 1'b0;
    check_eq("coincide_busy", {31'd0, busy}, 32'd1);
    while (busy && t < 900) step();
    check_eq("coincide_frame_end", t, 2 * POLL + 32 * HALF + 1);
    while (!busy && t < 1000) step();
    check_eq("coincide_next_start", t, 3 * POLL);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
